// File: rtl/sig_capture_pkg.sv
// rtl/sig_capture_pkg.sv - shared state type and defaults for the sig_capture trigger buffer
package sig_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } cap_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port sample-pair RAM, one write port and one registered read port
module capture_ram #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [A_WIDTH-1:0]     waddr,
    input  logic [2*D_WIDTH-1:0]   wdata,
    input  logic                   re,
    input  logic [A_WIDTH-1:0]     raddr,
    output logic [2*D_WIDTH-1:0]   rdata
);

    logic [2*D_WIDTH-1:0] mem [2**A_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads so the host sees stable data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sig_capture.sv
// rtl/sig_capture.sv - level-crossing triggered capture buffer; AUTO_TRIG_EN adds a timeout trigger
module sig_capture
    import sig_capture_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
`ifdef AUTO_TRIG_EN
    ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] din1,
    input  logic [D_WIDTH-1:0] din2,
    input  logic [D_WIDTH-1:0] trig_level,
    input  logic               arm,
    input  logic               abort,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [D_WIDTH-1:0] rd_data1,
    output logic [D_WIDTH-1:0] rd_data2,
    output logic               busy,
    output logic               done
);

    cap_state_t           state;
    logic [A_WIDTH-1:0]   wr_ptr;
    logic [A_WIDTH-1:0]   rd_ptr;
    logic [D_WIDTH-1:0]   prev1;
    logic                 first;
    logic                 crossing;
    logic                 trig;
    logic                 we;
    logic                 re;
    logic [2*D_WIDTH-1:0] rdata;

    // The first armed cycle only primes prev1, so an already-high signal cannot trigger.
    assign crossing = !first && (prev1 < trig_level) && (din1 >= trig_level);

`ifdef AUTO_TRIG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    logic [CNT_W-1:0] cnt;
    assign trig = crossing || (cnt == CNT_W'(TIMEOUT));
`else
    assign trig = crossing;
`endif

    assign we = !abort && (((state == ARMED) && trig) || (state == CAPTURE));
    assign re = !abort && (state == READOUT) && rd_en;

    assign busy = (state == ARMED) || (state == CAPTURE);
    assign done = (state == READOUT);

    capture_ram #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({din1, din2}),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign rd_data1 = rdata[2*D_WIDTH-1:D_WIDTH];
    assign rd_data2 = rdata[D_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            prev1    <= '0;
            first    <= 1'b1;
            rd_valid <= 1'b0;
`ifdef AUTO_TRIG_EN
            cnt      <= '0;
`endif
        end else begin
            rd_valid <= re;
            if (abort) begin
                state  <= IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                first  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state  <= ARMED;
                            first  <= 1'b1;
                            wr_ptr <= '0;
`ifdef AUTO_TRIG_EN
                            cnt    <= '0;
`endif
                        end
                    end
                    ARMED: begin
                        prev1 <= din1;
                        first <= 1'b0;
`ifdef AUTO_TRIG_EN
                        cnt   <= cnt + CNT_W'(1);
`endif
                        // Trigger pair lands at address 0 this cycle.
                        if (trig) begin
                            wr_ptr <= A_WIDTH'(1);
                            state  <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        wr_ptr <= wr_ptr + A_WIDTH'(1);
                        if (wr_ptr == '1) begin
                            state <= READOUT;
                        end
                    end
                    READOUT: begin
                        if (rd_en) begin
                            rd_ptr <= rd_ptr + A_WIDTH'(1);
                            if (rd_ptr == '1) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sig_capture.md
Name: sig_capture

Overview:
Triggered capture buffer that sits directly downstream of the dual-output sine generator and consumes its two sample streams (dout1, dout2). Once armed, it waits for a rising crossing of a programmable level on channel 1. It then records 2^A_WIDTH consecutive sample pairs into internal RAM and lets a host/display stage stream them out with a valid-qualified read interface.

Parameters:
D_WIDTH, 8, sample width (matches generator data width)
A_WIDTH, 8, capture depth = 2^A_WIDTH sample pairs
TIMEOUT, 1024, auto-trigger cycle count; used only with AUTO_TRIG_EN

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
din1  input  D_WIDTH  channel-1 sample (unsigned, offset-binary)
din2  input  D_WIDTH  channel-2 sample (phase-shifted stream)
trig_level  input  D_WIDTH  trigger threshold on din1
arm  input  1  one-cycle request to start a capture
abort  input  1  force return to IDLE from any state
rd_en  input  1  read request, one sample pair per cycle
rd_valid  output  1  rd_data1/rd_data2 valid this cycle
rd_data1  output  D_WIDTH  captured channel-1 sample
rd_data2  output  D_WIDTH  captured channel-2 sample
busy  output  1  high in ARMED or CAPTURE
done  output  1  high in READOUT (capture complete, data available)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wr_ptr=0, rd_ptr=0, prev1=0, first flag=1. Outputs rd_valid=0, rd_data1=0, rd_data2=0, busy=0, done=0. RAM contents are undefined.
- States: IDLE, ARMED, CAPTURE, READOUT; 2-bit encoding.
- IDLE: arm=1 -> ARMED next cycle, with first=1 and wr_ptr=0. All other inputs are ignored.
- ARMED:
  - Every cycle, prev1 <= din1.
  - First cycle after entry only loads prev1 (first <= 0). No trigger evaluation, so arming while the signal is already high cannot trigger.
  - Trigger condition: first=0 && prev1 < trig_level && din1 >= trig_level, compared unsigned.
  - On trigger: the triggering pair (din1, din2) is written at address 0, wr_ptr <= 1, state -> CAPTURE.
- CAPTURE: one pair is written per cycle at wr_ptr, and wr_ptr increments.
  - The write at address 2^A_WIDTH-1 moves state to READOUT; wr_ptr wraps to 0.
  - Capture latency: trigger sample at addr 0; sample k cycles later at addr k.
- READOUT:
  - rd_en=1 -> registered RAM read of rd_ptr. rd_valid=1 with that data on the next cycle; rd_ptr increments.
  - rd_en=0 -> rd_valid=0 next cycle. rd_data holds its last value.
  - The read accepted at rd_ptr=2^A_WIDTH-1 moves state to IDLE and rd_ptr to 0. The matching rd_valid pulse still appears in the following cycle (while in IDLE).
  - rd_en outside READOUT is ignored and produces no rd_valid.
- arm while not IDLE: ignored.
- abort=1: state -> IDLE next cycle from any state; wr_ptr, rd_ptr and first are reset. Any in-flight rd_valid for a read accepted the same cycle is suppressed. abort and arm in the same cycle: abort wins.
- busy and done are decoded combinationally from state registers (no glitch-sensitive logic).

Optional Feature:
AUTO_TRIG_EN.
- Defined: a cycle counter runs in ARMED, cleared on entry. If no trigger occurs within TIMEOUT cycles, a forced trigger is taken on cycle TIMEOUT with identical capture behaviour. A real trigger on the same cycle is treated as a normal trigger. A flat/DC input therefore still completes a capture.
- Not defined: no counter exists, and ARMED waits indefinitely for a level crossing or abort.

Decomposition:
- Package sig_capture_pkg holds:
  - cap_state_t enum (IDLE, ARMED, CAPTURE, READOUT)
  - localparam for the default TIMEOUT
- Sub-module capture_ram:
  - simple dual-port synchronous RAM, 2^A_WIDTH x 2*D_WIDTH
  - one write port, one registered read port
  - channel 1 in upper half of the word, channel 2 in lower half
- The FSM, pointers and trigger compare live in sig_capture.

Test Plan:
- Bench uses A_WIDTH=4 (16 samples). After reset, all outputs are 0 and state is IDLE. Pulse rd_en=1 -> rd_valid stays 0.
- Ramp din1=0,1,2,...; din2=din1+100; trig_level=5; arm -> trigger when din1=5. Read 16 -> rd_data1 = 5..20 and rd_data2 = 105..120, each one cycle after rd_en. busy falls and done rises on the cycle after the write of 20.
- Arm while din1=200 and falling toward 0 and rising again; trig_level=128 -> no trigger during the descent. Trigger occurs on the first sample >=128 of the ascent, and rd_data1[0] equals that sample.
- Mid-CAPTURE (after 6 writes), assert abort together with arm -> IDLE next cycle, done never asserts. A subsequent arm captures a full fresh buffer starting at addr 0.
- READOUT with rd_en toggled 1,0,1,... -> rd_valid follows one cycle late and addresses are consecutive without skips. The 16th read returns state to IDLE, with its rd_valid in the IDLE cycle.
- AUTO_TRIG_EN defined, TIMEOUT=20, din1 constant 10, trig_level=50 -> forced trigger exactly 20 cycles after entering ARMED, and all 16 captured samples = 10. Macro undefined -> still ARMED after 1000 cycles.
